tile_map_write_arbiter: RTL and testbench
=========================================

// Module: tile_map_write_arbiter
// PURPOSE
//  Owns the 12x17 background tile map read by the VGA drawer and shares its single
//  write path among game-logic requesters (coin collect, countdown digits, block hits).
//  Writes commit only during vertical blanking, so a frame never shows a half-updated map.
//  Round-robin arbitration, req/ack handshake, per-vblank write budget.
// PARAMETERS
//  NUM_REQ        3   number of requesters; index 0 is the lowest round-robin start
//  MAP_ROWS       12  tile rows (matches background [11:0])
//  MAP_COLS       17  tile columns (matches background [16:0])
//  SKY_TILE       1   reset value of every cell above ground
//  GND_TILE       3   reset value of bottom GND_ROWS rows
//  GND_ROWS       2   rows MAP_ROWS-GND_ROWS..MAP_ROWS-1 reset to GND_TILE
//  WRITE_BUDGET   16  maximum commits per vblank interval (1..255)
// PORTS
//  clk         in   1                   system clock (pixel domain)
//  reset_n     in   1                   synchronous, active-low reset
//  vblank      in   1                   level, high while the VGA scan is outside the visible area
//  req         in   NUM_REQ             per-requester write request, held until ack
//  req_row     in   NUM_REQ x int       target tile row, stable while req high
//  req_col     in   NUM_REQ x int       target tile column, stable while req high
//  req_tile    in   NUM_REQ x byte      tile code to write (BDR/SKY/BLK/GND/TKN/CLK)
//  ack         out  NUM_REQ             one-cycle pulse: request consumed
//  oob         out  1                   one-cycle pulse with ack when the row/col was out of range
//  background  out  byte [11:0][16:0]   registered tile map, to the drawer
//  busy        out  1                   any req pending and not yet acked
// BEHAVIOUR
//  Reset (reset_n low at a clk edge): all ack=0, oob=0, busy=0, rr pointer=0, budget count=0,
//   state=IDLE, background rows 0..9 = SKY_TILE, rows 10..11 = GND_TILE. Pending requests are dropped;
//   requesters must re-present them. Reset mid-grant cancels that write (cell keeps reset value).
//  States:
//   IDLE      vblank=0; no grants. -> ARB when vblank=1 (budget count cleared on this transition).
//   ARB       each cycle, eligible = req & ~ack; if any, grant first eligible at/after rr pointer.
//             -> EXHAUSTED when budget count reaches WRITE_BUDGET; -> IDLE when vblank=0.
//   EXHAUSTED no grants until vblank falls; -> IDLE when vblank=0.
//  Grant timing: cycle N req[i] high, state=ARB, vblank=1, i selected -> at edge ending N the cell
//   background[row][col] <= req_tile[i], ack[i]=1 during N+1, rr pointer <= (i+1) mod NUM_REQ,
//   budget count +1. Visible to the drawer from N+1. Max one commit per cycle.
//  Handshake: requester drops or changes req the cycle after seeing ack; ack masking stops a held
//   req from double-committing. A req high in N+1 for a different cell is a new request, eligible N+2.
//  vblank falling in cycle N: no grant in N (grant requires vblank=1 in the same cycle).
//  Out of range (row<0, row>=MAP_ROWS, col<0, col>=MAP_COLS): acked normally, no write, oob=1 with ack,
//   budget still charged.
//  Requests while vblank=0 wait; busy=1. No starvation: every eligible requester is granted within
//   NUM_REQ grants.
//  budget count is 8 bits, saturates at WRITE_BUDGET, never wraps.
// STRUCTURE
//  Shared package: tile code constants (BDR..CLK), MAP_ROWS/MAP_COLS, BLOCK_WIDTH, the arbiter
//   state enum.
//  Sub-module rr_arbiter (NUM_REQ wide: eligible vector + pointer -> one-hot grant, valid).
//  Map storage, FSM, and budget counter stay in the top.
// TESTING
//  Reset: reset_n=0 2 cycles -> background[5][3]=1, background[11][0]=3, ack=0, state IDLE.
//  Blanking hold: req[0] row4 col6 tile2 with vblank=0 for 50 cycles -> no ack, busy=1, cell unchanged;
//   raise vblank -> ack[0] next cycle, background[4][6]=2.
//  Round-robin: req[0..2] all high in vblank -> acks in order 0,1,2 on consecutive cycles; re-request
//   all -> order continues 0,1,2 from the pointer.
//  Budget: WRITE_BUDGET=4, 6 requests in one vblank -> 4 acks, 2 held until the next vblank, then acked.
//  Out of range: req row12 col0 -> ack with oob=1, no background cell changes, budget count +1.
//  Reset mid-operation: reset_n=0 during the grant cycle -> target cell = reset value, no ack in N+1.

Source files
------------

// File: rtl/tile_map_write_arbiter_pkg.sv
// Shared definitions for the background tile map and its write arbiter.
// Tile codes, map geometry, arbiter state encoding and a map-bounds helper.
package tile_map_write_arbiter_pkg;

  localparam int MAP_ROWS    = 12;
  localparam int MAP_COLS    = 17;
  localparam int BLOCK_WIDTH = 32;

  localparam logic [7:0] TILE_BDR = 8'd0;
  localparam logic [7:0] TILE_SKY = 8'd1;
  localparam logic [7:0] TILE_BLK = 8'd2;
  localparam logic [7:0] TILE_GND = 8'd3;
  localparam logic [7:0] TILE_TKN = 8'd4;
  localparam logic [7:0] TILE_CLK = 8'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARB       = 2'd1,
    ST_EXHAUSTED = 2'd2
  } arb_state_e;

  function automatic logic cell_in_map(input int row, input int col);
    return (row >= 0) && (row < MAP_ROWS) && (col >= 0) && (col < MAP_COLS);
  endfunction

endpackage

// File: rtl/tile_map_write_arbiter_if.sv
// Write-request bundle between game-logic requesters (master) and the tile map arbiter (slave).
interface tile_map_write_arbiter_if #(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0] req;
  int                 req_row  [NUM_REQ];
  int                 req_col  [NUM_REQ];
  logic [7:0]         req_tile [NUM_REQ];
  logic [NUM_REQ-1:0] ack;
  logic               oob;
  logic               busy;

  modport master (
    output req, req_row, req_col, req_tile,
    input  ack, oob, busy
  );

  modport slave (
    input  req, req_row, req_col, req_tile,
    output ack, oob, busy
  );

endinterface

// File: rtl/tile_map_write_arbiter_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after the pointer, as one-hot and index.
module tile_map_write_arbiter_rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             valid
);

  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = PTR_W'((int'(ptr) + k) % N);
      if (!valid && eligible[scan_idx]) begin
        valid           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

endmodule

// File: rtl/tile_map_write_arbiter.sv
// Background tile map owner; commits queued game-logic writes only during vblank,
// round-robin among requesters, at most WRITE_BUDGET commits per blanking interval.
//
// state        | meaning
// ST_IDLE      | visible scan, no grants; vblank rising clears the budget and opens ARB
// ST_ARB       | blanking, one grant per cycle to the round-robin winner
// ST_EXHAUSTED | budget spent for this blanking interval, hold until vblank falls
module tile_map_write_arbiter
  import tile_map_write_arbiter_pkg::*;
#(
  parameter int         NUM_REQ      = 3,
  parameter logic [7:0] SKY_TILE     = TILE_SKY,
  parameter logic [7:0] GND_TILE     = TILE_GND,
  parameter int         GND_ROWS     = 2,
  parameter int         WRITE_BUDGET = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     vblank,
  tile_map_write_arbiter_if.slave                  bus,
  output logic [MAP_ROWS-1:0][MAP_COLS-1:0][7:0]   background
);

  localparam int         PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int         ROW_W      = $clog2(MAP_ROWS);
  localparam int         COL_W      = $clog2(MAP_COLS);
  localparam logic [7:0] BUDGET_MAX = 8'(WRITE_BUDGET);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, ptr_next, grant_idx;
  logic [NUM_REQ-1:0] eligible, grant_oh;
  logic               grant_valid, grant_en, commit;
  logic [7:0]         budget_q;
  int                 sel_row, sel_col;
  logic [7:0]         sel_tile;
  logic               sel_in_map;

  // A request acked last cycle is masked so a held req cannot commit twice.
  assign eligible = bus.req & ~bus.ack;
  assign bus.busy = |(bus.req & ~bus.ack);

  tile_map_write_arbiter_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .ptr       (rr_ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  always_comb begin
    sel_row    = bus.req_row[grant_idx];
    sel_col    = bus.req_col[grant_idx];
    sel_tile   = bus.req_tile[grant_idx];
    sel_in_map = cell_in_map(sel_row, sel_col);
    ptr_next   = (int'(grant_idx) >= NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (vblank) state_d = ST_ARB;
      ST_ARB: begin
        if (!vblank)                                        state_d = ST_IDLE;
        else if (commit && (budget_q + 8'd1 >= BUDGET_MAX)) state_d = ST_EXHAUSTED;
      end
      ST_EXHAUSTED: if (!vblank) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_en = (state_q == ST_ARB) && vblank && (budget_q < BUDGET_MAX);
    commit   = grant_en && grant_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.ack  <= '0;
      bus.oob  <= 1'b0;
      rr_ptr_q <= '0;
      budget_q <= '0;
    end else begin
      bus.ack <= commit ? grant_oh : '0;
      bus.oob <= commit && !sel_in_map;
      if (commit) rr_ptr_q <= ptr_next;
      // Out-of-range requests are still charged against the budget.
      if (state_q == ST_IDLE && vblank)          budget_q <= '0;
      else if (commit && budget_q < BUDGET_MAX)  budget_q <= budget_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < MAP_ROWS; r++) begin
        for (int c = 0; c < MAP_COLS; c++) begin
          background[r][c] <= (r >= MAP_ROWS - GND_ROWS) ? GND_TILE : SKY_TILE;
        end
      end
    end else if (commit && sel_in_map) begin
      background[sel_row[ROW_W-1:0]][sel_col[COL_W-1:0]] <= sel_tile;
    end
  end

endmodule

// File: tb/tb_tile_map_write_arbiter.sv
// Directed and randomized bench for tile_map_write_arbiter against a frame-level map model.
module tb_tile_map_write_arbiter;
  import tile_map_write_arbiter_pkg::*;

  localparam int NREQ   = 3;
  localparam int BUDGET = 4;

  typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0][7:0] map_t;
  typedef struct {
    int         row;
    int         col;
    logic [7:0] tile;
  } job_t;

  logic clk = 1'b0;
  logic reset_n;
  logic vblank;
  map_t background;

  tile_map_write_arbiter_if #(.NUM_REQ(NREQ)) bus();

  tile_map_write_arbiter #(
    .NUM_REQ      (NREQ),
    .WRITE_BUDGET (BUDGET)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vblank     (vblank),
    .bus        (bus),
    .background (background)
  );

  always #5 clk = ~clk;

  // Requester job queues and the reference model state.
  job_t             jobs [NREQ][$];
  map_t             m_bg;
  logic [NREQ-1:0]  m_ack;
  logic             m_oob;
  int               m_rr;
  int               m_used;
  bit               m_prev_vb;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_log[$];
  int ack_count;
  int oob_count;
  bit hit;

  function automatic map_t reset_map();
    map_t m;
    for (int r = 0; r < MAP_ROWS; r++)
      for (int c = 0; c < MAP_COLS; c++)
        m[r][c] = (r >= MAP_ROWS - 2) ? 8'd3 : 8'd1;
    return m;
  endfunction

  function automatic int count_diff();
    int n = 0;
    for (int r = 0; r < MAP_ROWS; r++)
      for (int c = 0; c < MAP_COLS; c++)
        if (background[r][c] !== m_bg[r][c]) n++;
    return n;
  endfunction

  // Which requester the spec says wins the edge that ends the current cycle (-1: none).
  function automatic int predict();
    if (reset_n !== 1'b1 || vblank !== 1'b1 || !m_prev_vb || m_used >= BUDGET) return -1;
    for (int k = 0; k < NREQ; k++)
      if (bus.req[(m_rr + k) % NREQ] && !m_ack[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (jobs[i].size() > 0) begin
        bus.req[i]      = 1'b1;
        bus.req_row[i]  = jobs[i][0].row;
        bus.req_col[i]  = jobs[i][0].col;
        bus.req_tile[i] = jobs[i][0].tile;
      end else begin
        bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    int         g;
    bit         rst_now, vb_now;
    int         row, col;
    logic [7:0] tile;
    g       = predict();
    rst_now = (reset_n !== 1'b1);
    vb_now  = (vblank === 1'b1);
    row = 0; col = 0; tile = '0;
    if (g >= 0) begin
      row  = bus.req_row[g];
      col  = bus.req_col[g];
      tile = bus.req_tile[g];
    end
    @(posedge clk);
    #1;
    if (rst_now) begin
      m_bg = reset_map(); m_ack = '0; m_oob = 1'b0;
      m_rr = 0; m_used = 0; m_prev_vb = 1'b0;
      for (int i = 0; i < NREQ; i++) jobs[i].delete();
    end else begin
      m_ack = '0; m_oob = 1'b0;
      if (g >= 0) begin
        m_ack[g] = 1'b1;
        if (row >= 0 && row < MAP_ROWS && col >= 0 && col < MAP_COLS) m_bg[row[3:0]][col[4:0]] = tile;
        else m_oob = 1'b1;
        m_rr = (g + 1) % NREQ;
        m_used++;
      end
      if (vb_now && !m_prev_vb) m_used = 0;
      m_prev_vb = vb_now;
    end
    chk("ack", 32'(bus.ack), 32'(m_ack));
    chk("oob", 32'(bus.oob), 32'(m_oob));
    n_checks++;
    assert (background === m_bg) else begin
      n_fail++;
      $error("FAIL map observed_bad_cells=%0d expected_bad_cells=0", count_diff());
    end
    for (int i = 0; i < NREQ; i++) if (bus.ack[i] === 1'b1) dut_log.push_back(i);
    ack_count += $countones(bus.ack);
    if (bus.oob === 1'b1) oob_count++;
    for (int i = 0; i < NREQ; i++) if (m_ack[i] && jobs[i].size() > 0) void'(jobs[i].pop_front());
    drive();
    #1;
    chk("busy", 32'(bus.busy), 32'(|(bus.req & ~m_ack)));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vblank  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push(input int i, input int row, input int col, input logic [7:0] tile);
    job_t j;
    j.row = row; j.col = col; j.tile = tile;
    jobs[i].push_back(j);
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_n"}, 32'(dut_log.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_%0d", tag, k), (k < dut_log.size()) ? dut_log[k] : -1, k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; vblank = 1'b0; bus.req = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_row[i] = 0; bus.req_col[i] = 0; bus.req_tile[i] = '0;
    end
    m_ack = '0; m_oob = 1'b0; m_rr = 0; m_used = 0; m_prev_vb = 1'b0;
    ack_count = 0; oob_count = 0;

    // Reset values.
    tick(); tick();
    chk("rst_cell_5_3", 32'(background[5][3]), 32'd1);
    chk("rst_cell_11_0", 32'(background[11][0]), 32'd3);
    chk("rst_cell_9_16", 32'(background[9][16]), 32'd1);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;

    // Requests wait through the visible scan.
    push(0, 4, 6, TILE_BLK); drive();
    ack_count = 0;
    repeat (50) tick();
    chk("hold_noack", 32'(ack_count), 32'd0);
    chk("hold_busy", 32'(bus.busy), 32'd1);
    chk("hold_cell", 32'(background[4][6]), 32'd1);
    vblank = 1'b1;
    tick(); tick();
    chk("hold_ack0", 32'(bus.ack), 32'b001);
    chk("hold_cell_written", 32'(background[4][6]), 32'd2);

    // Round-robin order from a fresh pointer, then continuing from it.
    do_reset();
    push(0, 1, 0, TILE_BLK); push(1, 1, 1, TILE_TKN); push(2, 1, 2, TILE_CLK);
    drive(); vblank = 1'b1; dut_log.delete();
    repeat (5) tick();
    chk_order("rr1");
    vblank = 1'b0; repeat (2) tick();
    push(0, 2, 0, TILE_TKN); push(1, 2, 1, TILE_CLK); push(2, 2, 2, TILE_BLK);
    drive(); vblank = 1'b1; dut_log.delete();
    repeat (5) tick();
    chk_order("rr2");

    // Per-vblank budget: six requests, four commit now, two next interval.
    vblank = 1'b0; repeat (2) tick();
    for (int i = 0; i < NREQ; i++) begin
      push(i, 3, i, TILE_GND);
      push(i, 5, 10 + i, TILE_TKN);
    end
    drive(); ack_count = 0; vblank = 1'b1;
    repeat (20) tick();
    chk("budget_win1", 32'(ack_count), 32'd4);
    ack_count = 0; vblank = 1'b0;
    repeat (3) tick();
    chk("budget_low", 32'(ack_count), 32'd0);
    chk("budget_busy", 32'(bus.busy), 32'd1);
    vblank = 1'b1;
    repeat (20) tick();
    chk("budget_win2", 32'(ack_count), 32'd2);

    // Out-of-range request is acked with oob, no write, budget still charged.
    vblank = 1'b0; repeat (2) tick();
    push(0, 12, 0, TILE_CLK); push(0, 6, 6, TILE_BLK);
    push(1, 7, 7, TILE_BLK);  push(1, 8, 8, TILE_BLK);
    push(2, 0, 16, TILE_BDR); push(2, 0, 15, TILE_BDR);
    drive(); ack_count = 0; oob_count = 0; vblank = 1'b1;
    repeat (20) tick();
    chk("oob_acks", 32'(ack_count), 32'd4);
    chk("oob_pulses", 32'(oob_count), 32'd1);
    chk("oob_cell_11_0", 32'(background[11][0]), 32'd3);

    // Reset asserted in the grant cycle cancels the write and the ack.
    do_reset();
    push(0, 2, 2, TILE_CLK); drive(); vblank = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if (predict() == 0) begin
        reset_n = 1'b0;
        hit = 1'b1;
      end
      tick();
    end
    chk("midrst_hit", 32'(hit), 32'd1);
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_cell", 32'(background[2][2]), 32'd1);
    reset_n = 1'b1; vblank = 1'b0;
    tick();

    // Randomized traffic with occasional resets, including out-of-range cells.
    for (int c = 0; c < 600; c++) begin
      vblank  = ((c % 40) >= 26);
      reset_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (jobs[i].size() == 0 && $urandom_range(0, 2) == 0)
          push(i, int'($urandom_range(0, 13)) - 1, int'($urandom_range(0, 18)) - 1,
               8'($urandom_range(0, 5)));
      end
      drive();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
